aplic_reg_initiator: RTL

APLIC_REG_INITIATOR -- requirements
Module: aplic_reg_initiator

---
 rtl/aplic_reg_init_pkg.sv | 34 +++
 rtl/aplic_reg_initiator.sv | 123 ++++++++++++
 2 files changed

// File: rtl/aplic_reg_init_pkg.sv
// Shared types and widths for the APLIC register-interface initiator.
// Holds the FSM state encoding, bus widths and the register-interface field bundles.
package aplic_reg_init_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } state_e;

    // Request fields held stable for the whole REQ phase.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
        logic              write;
    } reg_req_t;

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic              error;
        logic              ready;
    } reg_rsp_t;

    // Counter width able to hold the timeout limit; at least one bit.
    function automatic int cnt_width(input int unsigned limit);
        return (limit < 2) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/aplic_reg_initiator.sv
// Single-outstanding command initiator onto the APLIC register interface.
// Commands are captured in IDLE, presented in REQ until ready or timeout, and returned in RSP.
module aplic_reg_initiator
    import aplic_reg_init_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [DATA_W-1:0] i_cmd_wdata,
    input  logic              i_cmd_write,
    input  logic [STRB_W-1:0] i_cmd_wstrb,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_rsp_error,
    output logic              o_rsp_timeout,
    output logic [ADDR_W-1:0] reg_intf_req_a32_d32_addr,
    output logic [DATA_W-1:0] reg_intf_req_a32_d32_wdata,
    output logic [STRB_W-1:0] reg_intf_req_a32_d32_wstrb,
    output logic              reg_intf_req_a32_d32_write,
    output logic              reg_intf_req_a32_d32_valid,
    input  logic [DATA_W-1:0] reg_intf_resp_d32_rdata,
    input  logic              reg_intf_resp_d32_error,
    input  logic              reg_intf_resp_d32_ready,
    output logic              o_busy
);

    localparam int             CNT_W      = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W:0] LIMIT      = (CNT_W + 1)'(TIMEOUT_CYCLES);
    localparam bit             TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    state_e            r_state;
    reg_req_t          r_req;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_rdata;
    logic              r_error;
    logic              r_timeout;

    reg_rsp_t          w_rsp;
    logic              w_in_req;
    logic              w_in_rsp;
    logic [CNT_W:0]    w_cnt_inc;
    logic              w_cnt_sat;
    logic              w_timeout_hit;

    assign w_rsp.rdata = reg_intf_resp_d32_rdata;
    assign w_rsp.error = reg_intf_resp_d32_error;
    assign w_rsp.ready = reg_intf_resp_d32_ready;

    assign w_in_req = (r_state == ST_REQ);
    assign w_in_rsp = (r_state == ST_RSP);

    // The limit is hit on the REQ cycle whose increment would make the count equal TIMEOUT_CYCLES.
    assign w_cnt_inc     = {1'b0, r_cnt} + 1'b1;
    assign w_cnt_sat     = &r_cnt;
    assign w_timeout_hit = TIMEOUT_EN && (w_cnt_inc == LIMIT);

    assign o_cmd_ready   = (r_state == ST_IDLE);
    assign o_busy        = (r_state != ST_IDLE);
    assign o_rsp_valid   = w_in_rsp;
    assign o_rsp_rdata   = r_rdata;
    assign o_rsp_error   = r_error;
    assign o_rsp_timeout = r_timeout;

    assign reg_intf_req_a32_d32_valid = w_in_req;
    assign reg_intf_req_a32_d32_addr  = w_in_req ? r_req.addr  : '0;
    assign reg_intf_req_a32_d32_wdata = w_in_req ? r_req.wdata : '0;
    assign reg_intf_req_a32_d32_wstrb = w_in_req ? r_req.wstrb : '0;
    assign reg_intf_req_a32_d32_write = w_in_req ? r_req.write : 1'b0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_req     <= '0;
            r_cnt     <= '0;
            r_rdata   <= '0;
            r_error   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_cmd_valid) begin
                        r_req.addr  <= i_cmd_addr;
                        r_req.write <= i_cmd_write;
                        r_req.wdata <= i_cmd_write ? i_cmd_wdata : '0;
                        r_req.wstrb <= i_cmd_write ? i_cmd_wstrb : '0;
                        r_cnt       <= '0;
                        r_state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // Ready on the limit cycle still completes normally.
                    if (w_rsp.ready) begin
                        r_rdata   <= r_req.write ? '0 : w_rsp.rdata;
                        r_error   <= w_rsp.error;
                        r_timeout <= 1'b0;
                        r_state   <= ST_RSP;
                    end else if (w_timeout_hit) begin
                        r_rdata   <= '0;
                        r_error   <= 1'b1;
                        r_timeout <= 1'b1;
                        r_state   <= ST_RSP;
                    end else if (!w_cnt_sat) begin
                        r_cnt <= w_cnt_inc[CNT_W-1:0];
                    end
                end
                ST_RSP: begin
                    if (i_rsp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
